// File: rtl/icache_direct_pkg.sv
// rtl/icache_direct_pkg.sv - shared constants, state encoding and default geometry for icache_direct
package icache_direct_pkg;

  localparam logic        True   = 1'b1;
  localparam logic        False  = 1'b0;
  localparam logic [31:0] null32 = 32'h0000_0000;

  localparam int ICACHE_INDEX_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - valid/tag/data storage, combinational read, one synchronous write
module icache_line_array
  import icache_direct_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // Only the valid bits need clearing; stale tag/data are masked by valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= True;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped instruction cache; ICACHE_PERF_EN adds hit/miss counters
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int ADDR_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  icache_state_e state, state_n;
  logic          inst_valid_n, mem_req_n;
  logic [31:0]   inst_n, mem_addr_n;
  logic          wr_en, hit, hit_acc, miss_acc;
  logic          rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]   rd_data;

  icache_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_lines (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_addr[INDEX_W+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en && rdy),
    .wr_idx   (mem_addr[INDEX_W+1:2]),
    .wr_tag   (mem_addr[ADDR_W-1:INDEX_W+2]),
    .wr_data  (mem_data)
  );

  assign hit = rd_valid && (rd_tag == fetch_addr[ADDR_W-1:INDEX_W+2]);

  always_comb begin
    state_n      = state;
    inst_valid_n = False;
    inst_n       = inst;
    mem_req_n    = mem_req;
    mem_addr_n   = mem_addr;
    wr_en        = False;
    hit_acc      = False;
    miss_acc     = False;
    if (jp_wrong) begin
      state_n   = IDLE;
      mem_req_n = False;
      // A refill landing with the flush is still correct data for mem_addr.
      wr_en     = (state == MISS) && mem_done;
    end else if (state == IDLE) begin
      // Requests are ignored while inst_valid is high, giving one word per 2 cycles.
      if (fetch_req && !inst_valid) begin
        if (hit) begin
          inst_valid_n = True;
          inst_n       = rd_data;
          hit_acc      = True;
        end else begin
          mem_req_n  = True;
          mem_addr_n = {fetch_addr[31:2], 2'b00};
          state_n    = MISS;
          miss_acc   = True;
        end
      end
    end else if (mem_done) begin
      wr_en        = True;
      inst_valid_n = True;
      inst_n       = mem_data;
      mem_req_n    = False;
      state_n      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      inst_valid <= False;
      inst       <= null32;
      mem_req    <= False;
      mem_addr   <= null32;
    end else if (rdy) begin
      state      <= state_n;
      inst_valid <= inst_valid_n;
      inst       <= inst_n;
      mem_req    <= mem_req_n;
      mem_addr   <= mem_addr_n;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= null32;
      miss_cnt <= null32;
    end else if (rdy) begin
      if (hit_acc && hit_cnt != 32'hFFFF_FFFF)   hit_cnt  <= hit_cnt + 32'd1;
      if (miss_acc && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = hit_acc | miss_acc;
`endif

  logic unused_addr;
  assign unused_addr = &{1'b0, fetch_addr[1:0]};

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped instruction cache between the instruction-fetch stage and the memory controller's IC port.
- Serves 32-bit instruction words to IF. On a miss, holds a single-word refill request to the memory controller until it returns the word.
- Supports branch-mispredict flush (jp_wrong) and the global rdy stall.

Parameters:
- INDEX_W, 8, line-index bits (2^INDEX_W lines, one 32-bit word per line)
- ADDR_W, 18, significant address bits; the tag is addr[ADDR_W-1 : INDEX_W+2]

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low, all state is frozen
- jp_wrong  in  1  mispredict flush
- fetch_req  in  1  IF requests the word at fetch_addr
- fetch_addr  in  32  byte address; bits [1:0] are ignored
- inst_valid  out  1  single-cycle pulse: inst is valid for the accepted request
- inst  out  32  instruction word
- mem_req  out  1  refill request to the memory controller, held until mem_done
- mem_addr  out  32  word-aligned refill address
- mem_done  in  1  memory controller returns the word (single-cycle pulse)
- mem_data  in  32  refill word, valid with mem_done

Behaviour:
- Reset, and all outputs after reset:
  - inst_valid=0, inst=0, mem_req=0, mem_addr=0.
  - All valid bits cleared. State=IDLE.
- Stall: if rdy=0, nothing changes; outputs hold their registered values.
- State IDLE, fetch_req=1, jp_wrong=0:
  - Hit (valid[idx] and tag match): next cycle inst_valid=1, inst=data[idx]. State stays IDLE. Hit latency is 1 cycle.
  - Miss: next cycle mem_req=1 and mem_addr={fetch_addr[31:2],2'b00}. State becomes MISS.
- State MISS:
  - mem_req and mem_addr stay stable.
  - fetch_addr is not re-sampled; IF holds it constant until inst_valid or jp_wrong.
- mem_done in MISS, jp_wrong=0:
  - Next cycle: line written (data, tag, valid=1), inst_valid=1, inst=mem_data, mem_req=0. State returns to IDLE.
  - Miss latency = memory latency + 1.
- inst_valid is a single-cycle pulse. A new request is accepted in the cycle after inst_valid; back-to-back hits therefore give one word every 2 cycles.
- jp_wrong=1, any state:
  - Next cycle: inst_valid=0, mem_req=0, state=IDLE.
  - fetch_req in that same cycle is ignored.
- jp_wrong and mem_done in the same cycle:
  - The line is still written, because the data is correct for mem_addr.
  - inst_valid is suppressed.
- mem_done outside MISS: ignored, no write.
- fetch_req=0 in IDLE: idle, inst_valid=0.
- Index = addr[INDEX_W+1:2]. Address bits above ADDR_W are ignored in the tag compare.
- No write path; the cache is read-only and never invalidated except by reset.

Optional Feature:
- Macro: ICACHE_PERF_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - hit_cnt increments on each hit acceptance; miss_cnt on each IDLE->MISS transition.
  - Both saturate at 32'hFFFFFFFF.
  - Both freeze when rdy=0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file:
  - existing True/False/null32 constants
  - ICACHE state encodings IDLE=1'b0, MISS=1'b1
  - ICACHE_INDEX_W default
- Sub-module icache_line_array:
  - holds valid/tag/data arrays
  - combinational read port (idx -> valid, tag, data)
  - one synchronous write port
  - synchronous valid clear on rst

Test Plan:
- Reset, then fetch_req with fetch_addr=0x0000 -> mem_req=1 and mem_addr=0x0000 next cycle. Then mem_done with mem_data=0x00000013 -> next cycle inst_valid=1, inst=0x00000013.
- Re-fetch 0x0000 after the fill -> inst_valid=1 exactly 1 cycle later, inst=0x00000013, mem_req stays 0.
- Conflict, with INDEX_W=8:
  - fill 0x0004, then fetch 0x0404 (same index) -> miss, mem_addr=0x0404.
  - after refill with 0xDEADBEEF, fetching 0x0004 misses again.
- Mispredict:
  - jp_wrong in MISS before mem_done -> mem_req=0 next cycle, no inst_valid; a later mem_done is ignored.
  - jp_wrong coinciding with mem_done for 0x0008 -> no inst_valid, but a subsequent fetch of 0x0008 hits in 1 cycle.
- rdy held low for 5 cycles while in MISS with mem_done pulsed in that window -> no state change. mem_done arriving after rdy returns -> normal fill.
- ICACHE_PERF_EN: 3 misses + 2 hits -> miss_cnt=3, hit_cnt=2. Reset -> both 0.
